// File: rtl/cfa_frame_ctrl.sv
`timescale 1ns/1ps
// Purpose: tracks raw sensor timing, emits pixel coordinates, Bayer phase, border flag and geometry error flags.
// Latency: 1 cycle from in_* sample to out_*/px_* (all outputs registered).
// Backpressure: none on the pixel stream; a config request stalls (cfg_ready=0) until committed at a frame start.
module cfa_frame_ctrl #(
    parameter int unsigned source_h      = 1024,
    parameter int unsigned source_v      = 1024,
    parameter logic [1:0]  raw_type_init = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_vsync,
    input  logic        in_hsync,
    input  logic        in_den,
    input  logic [1:0]  cfg_raw_type,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        err_clr,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic        out_den,
    output logic [11:0] px_x,
    output logic [11:0] px_y,
    output logic [1:0]  px_phase,
    output logic        px_border,
    output logic [1:0]  active_raw_type,
    output logic        frame_active,
    output logic        frame_done,
    output logic [2:0]  err_status
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [12:0] H_LEN   = 13'(source_h);
    localparam logic [12:0] V_LINES = 13'(source_v);
    localparam logic [11:0] X_LAST  = 12'(source_h - 1);
    localparam logic [11:0] Y_LAST  = 12'(source_v - 1);
    localparam logic [11:0] CNT_MAX = 12'hFFF;
    localparam logic [12:0] LINE_MAX = 13'd4096;

    state_t      state;
    state_t      state_nxt;
    logic        start_frame;
    logic        end_frame;

    logic [11:0] col_cnt;
    logic [12:0] line_cnt;
    logic [12:0] line_cnt_nxt;
    logic [12:0] y_dec;
    logic [11:0] x_nxt;
    logic [11:0] y_nxt;
    logic        pending;
    logic [1:0]  pend_type;
    logic [1:0]  active_nxt;
    logic [1:0]  phase_off;
    logic        cfg_accept;
    logic        pending_nxt;
    logic        in_frame;
    logic        hs_rise;
    logic        hs_fall;
    logic [2:0]  err_set;

    // Previous in_hsync sample is out_hsync, so edges need no extra flop.
    assign in_frame   = (state == ST_FRAME);
    assign hs_rise    = in_hsync & ~out_hsync;
    assign hs_fall    = ~in_hsync & out_hsync;
    assign cfg_accept = cfg_valid & cfg_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_WAIT;
        else       state <= state_nxt;
    end

    // Next-state decode; start/end strobes mark the frame boundary edges.
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state)
            ST_WAIT:  if (!in_vsync) state_nxt = ST_IDLE;
            ST_IDLE:  if (in_vsync) begin
                          state_nxt   = ST_FRAME;
                          start_frame = 1'b1;
                      end
            ST_FRAME: if (!in_vsync) begin
                          state_nxt = ST_DONE;
                          end_frame = 1'b1;
                      end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_WAIT;
        endcase
    end

    // Pixel-attribute next values; the line counter holds "lines started",
    // so y is that count minus one (line 0 starts at count 1).
    always_comb begin
        line_cnt_nxt = line_cnt;
        if (start_frame)
            line_cnt_nxt = 13'd0;
        else if (in_frame && hs_rise && line_cnt != LINE_MAX)
            line_cnt_nxt = line_cnt + 13'd1;

        y_dec = line_cnt_nxt - 13'd1;
        y_nxt = (line_cnt_nxt == 13'd0) ? 12'd0 : y_dec[11:0];
        x_nxt = (in_frame && in_hsync) ? col_cnt : 12'd0;

        active_nxt = (start_frame && pending) ? pend_type : active_raw_type;
        case (active_nxt)
            2'd0:    phase_off = 2'b11;   // BGGR
            2'd1:    phase_off = 2'b00;   // RGGB
            2'd2:    phase_off = 2'b10;   // GBRG
            default: phase_off = 2'b01;   // GRBG
        endcase

        pending_nxt = pending;
        if (cfg_accept)
            pending_nxt = 1'b1;
        else if (start_frame)
            pending_nxt = 1'b0;

        err_set[0] = in_frame & hs_fall & ({1'b0, col_cnt} != H_LEN);
        err_set[1] = end_frame & (line_cnt_nxt != V_LINES);
        err_set[2] = in_frame & in_den & ~in_hsync;
    end

    // Column and line counters; counting is confined to tracked frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt  <= 12'd0;
            line_cnt <= 13'd0;
        end else begin
            line_cnt <= line_cnt_nxt;
            if (!in_frame || !in_hsync)
                col_cnt <= 12'd0;
            else if (in_den && col_cnt != CNT_MAX)
                col_cnt <= col_cnt + 12'd1;
        end
    end

    // Config holding register; committed only on the frame-start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending         <= 1'b0;
            pend_type       <= 2'd0;
            cfg_ready       <= 1'b1;
            active_raw_type <= raw_type_init;
        end else begin
            pending         <= pending_nxt;
            cfg_ready       <= ~pending_nxt;
            active_raw_type <= active_nxt;
            if (cfg_accept)
                pend_type <= cfg_raw_type;
        end
    end

    // Registered datapath-facing outputs and sticky errors (a new error beats err_clr).
    always_ff @(posedge clk) begin
        if (reset) begin
            out_vsync    <= 1'b0;
            out_hsync    <= 1'b0;
            out_den      <= 1'b0;
            px_x         <= 12'd0;
            px_y         <= 12'd0;
            px_phase     <= 2'd0;
            px_border    <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            err_status   <= 3'd0;
        end else begin
            out_vsync    <= in_vsync;
            out_hsync    <= in_hsync;
            out_den      <= in_den;
            px_x         <= x_nxt;
            px_y         <= y_nxt;
            px_phase     <= {y_nxt[0], x_nxt[0]} ^ phase_off;
            px_border    <= (x_nxt == 12'd0) | (y_nxt == 12'd0) |
                            (x_nxt == X_LAST) | (y_nxt == Y_LAST);
            frame_active <= (state_nxt == ST_FRAME);
            frame_done   <= (state_nxt == ST_DONE);
            err_status   <= (err_clr ? 3'd0 : err_status) | err_set;
        end
    end

endmodule

// File: tb/tb_cfa_frame_ctrl.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for cfa_frame_ctrl on a 4x4 geometry (frame table, random frames, reset corner).
// Latency: expects px_*/out_* one cycle after the sampled input; sampled 1 ns after each rising edge.
// Backpressure: config requests are issued only when the model says the holding register is free.
module tb_cfa_frame_ctrl;

    localparam int         H    = 4;
    localparam int         V    = 4;
    localparam logic [1:0] INIT = 2'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_vsync = 1'b0, in_hsync = 1'b0, in_den = 1'b0;
    logic [1:0]  cfg_raw_type = 2'd0;
    logic        cfg_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic        cfg_ready;
    logic        out_vsync, out_hsync, out_den;
    logic [11:0] px_x, px_y;
    logic [1:0]  px_phase;
    logic        px_border;
    logic [1:0]  active_raw_type;
    logic        frame_active, frame_done;
    logic [2:0]  err_status;

    cfa_frame_ctrl #(.source_h(H), .source_v(V), .raw_type_init(INIT)) dut (
        .clk(clk), .reset(reset),
        .in_vsync(in_vsync), .in_hsync(in_hsync), .in_den(in_den),
        .cfg_raw_type(cfg_raw_type), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .err_clr(err_clr),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
        .px_x(px_x), .px_y(px_y), .px_phase(px_phase), .px_border(px_border),
        .active_raw_type(active_raw_type), .frame_active(frame_active),
        .frame_done(frame_done), .err_status(err_status)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: pattern in force, request waiting for a frame start, sticky errors.
    logic [1:0] m_active;
    bit         m_pend;
    logic [1:0] m_pend_val;
    logic [2:0] m_err;

    typedef struct {
        int         nl;
        int         bad_line;
        int         bad_len;
        bit         den_out;
        bit         cfg_req;
        logic [1:0] cfg_val;
        logic [2:0] exp_err;
    } frame_vec_t;

    frame_vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic h, input logic d);
        in_vsync = v;
        in_hsync = h;
        in_den   = d;
        @(posedge clk);
        #1;
    endtask

    // Colour seen at (y,x) for a given pattern, read off the 2x2 tile in raster order.
    // Codes: R=0, Gr=1 (green on a red row), Gb=2 (green on a blue row), B=3.
    function automatic logic [1:0] colour(input logic [1:0] t, input int y, input int x);
        logic [1:0] tile [4];
        case (t)
            2'd0:    tile = '{2'd3, 2'd2, 2'd1, 2'd0};   // B  Gb / Gr R
            2'd1:    tile = '{2'd0, 2'd1, 2'd2, 2'd3};   // R  Gr / Gb B
            2'd2:    tile = '{2'd2, 2'd3, 2'd0, 2'd1};   // Gb B  / R  Gr
            default: tile = '{2'd1, 2'd0, 2'd3, 2'd2};   // Gr R  / B  Gb
        endcase
        return tile[(y % 2) * 2 + (x % 2)];
    endfunction

    task automatic check_reset_vals();
        chk("rst_out_vsync", out_vsync, 0);
        chk("rst_out_hsync", out_hsync, 0);
        chk("rst_out_den", out_den, 0);
        chk("rst_px_x", px_x, 0);
        chk("rst_px_y", px_y, 0);
        chk("rst_px_phase", px_phase, 0);
        chk("rst_px_border", px_border, 0);
        chk("rst_active_raw_type", active_raw_type, INIT);
        chk("rst_frame_active", frame_active, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_status", err_status, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
    endtask

    // One line of len den cycles (optionally preceded by a blank hsync cycle), then two blank cycles.
    task automatic drive_line(input int j, input int len, input bit lead, input bit cfg_req,
                              input logic [1:0] cfg_val, input bit den_out);
        if (lead) step(1, 1, 0);
        for (int i = 0; i < len; i++) begin
            if (cfg_req && i == 0) begin
                chk("cfg_ready_before_req", cfg_ready, !m_pend);
                cfg_valid    = 1'b1;
                cfg_raw_type = cfg_val;
            end
            step(1, 1, 1);
            if (cfg_req && i == 0) begin
                cfg_valid  = 1'b0;
                m_pend     = 1'b1;
                m_pend_val = cfg_val;
                chk("cfg_ready_after_accept", cfg_ready, 0);
                chk("active_held_midframe", active_raw_type, m_active);
            end
            chk("px_x", px_x, i);
            chk("px_y", px_y, j);
            chk("px_phase", px_phase, colour(m_active, j, i));
            chk("px_border", px_border, (i == 0 || j == 0 || i == H - 1 || j == V - 1));
            chk("out_den", out_den, 1);
        end
        step(1, 0, 0);
        if (len != H) m_err[0] = 1'b1;
        chk("err_after_hsync_fall", err_status, m_err);
        if (den_out) begin
            err_clr = 1'b1;
            step(1, 0, 1);
            err_clr = 1'b0;
            m_err = 3'b100;
            chk("err_den_outside_vs_clr", err_status, m_err);
        end else begin
            step(1, 0, 0);
        end
    endtask

    task automatic frame_start();
        step(0, 0, 0);
        step(0, 0, 0);
        chk("frame_active_idle", frame_active, 0);
        step(1, 0, 0);
        if (m_pend) begin
            m_active = m_pend_val;
            m_pend   = 1'b0;
        end
        chk("frame_active_start", frame_active, 1);
        chk("active_at_start", active_raw_type, m_active);
        chk("cfg_ready_at_start", cfg_ready, !m_pend);
    endtask

    task automatic send_frame(input frame_vec_t f);
        frame_start();
        for (int j = 0; j < f.nl; j++)
            drive_line(j, (j == f.bad_line) ? f.bad_len : H, (j % 2) == 1,
                       f.cfg_req && j == 1, f.cfg_val, f.den_out && j == 0);
        step(0, 0, 0);
        if (f.nl != V) m_err[1] = 1'b1;
        chk("frame_done_pulse", frame_done, 1);
        chk("err_at_done_model", err_status, m_err);
        chk("err_at_done_expected", err_status, f.exp_err);
        err_clr = 1'b1;
        step(0, 0, 0);
        err_clr = 1'b0;
        m_err = 3'b000;
        chk("frame_done_single", frame_done, 0);
        chk("err_cleared", err_status, 0);
    endtask

    initial begin
        frame_vec_t f;

        //          nl bad_line bad_len den_out cfg_req cfg_val exp_err
        tbl[0] = '{4, -1, 4, 1'b0, 1'b0, 2'd0, 3'b000};   // clean RGGB 4x4
        tbl[1] = '{4, -1, 4, 1'b0, 1'b1, 2'd0, 3'b000};   // BGGR requested mid-frame
        tbl[2] = '{4,  1, 3, 1'b0, 1'b0, 2'd0, 3'b001};   // short line
        tbl[3] = '{3, -1, 4, 1'b0, 1'b0, 2'd0, 3'b010};   // too few lines
        tbl[4] = '{4, -1, 4, 1'b1, 1'b0, 2'd0, 3'b100};   // den outside hsync
        tbl[5] = '{3,  0, 3, 1'b1, 1'b0, 2'd0, 3'b110};   // line-0 error cleared by err_clr
        tbl[6] = '{5,  2, 5, 1'b0, 1'b1, 2'd3, 3'b011};   // long line, extra line, GRBG req
        tbl[7] = '{4, -1, 4, 1'b0, 1'b1, 2'd2, 3'b000};   // GBRG req, GRBG in force

        m_active   = INIT;
        m_pend     = 1'b0;
        m_pend_val = 2'd0;
        m_err      = 3'b000;

        // Reset state, with a config request that must be ignored.
        reset     = 1'b1;
        cfg_valid = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        cfg_valid = 1'b0;
        check_reset_vals();
        reset = 1'b0;

        for (int k = 0; k < 8; k++)
            send_frame(tbl[k]);

        // Reset at line 2: the remainder of that frame must be ignored.
        frame_start();
        drive_line(0, 3, 1'b0, 1'b0, 2'd0, 1'b0);
        drive_line(1, H, 1'b1, 1'b1, 2'd2, 1'b0);
        reset        = 1'b1;
        cfg_valid    = 1'b1;
        cfg_raw_type = 2'd3;
        step(1, 1, 1);
        cfg_valid = 1'b0;
        check_reset_vals();
        reset    = 1'b0;
        m_active = INIT;
        m_pend   = 1'b0;
        m_err    = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1);
            chk("ignored_px_x", px_x, 0);
        end
        step(1, 0, 0);
        chk("ignored_line_err", err_status, 0);
        step(1, 1, 1);
        step(1, 1, 1);
        step(1, 0, 0);
        chk("ignored_short_line_err", err_status, 0);
        step(0, 0, 0);
        chk("ignored_no_done", frame_done, 0);
        chk("ignored_not_active", frame_active, 0);
        step(0, 0, 0);
        chk("ignored_no_done2", frame_done, 0);
        send_frame(tbl[0]);

        // Randomised frames; expected end-of-frame errors derived from the frame description.
        for (int r = 0; r < 20; r++) begin
            f.nl       = $urandom_range(2, 6);
            f.bad_line = $urandom_range(0, f.nl);
            f.bad_len  = $urandom_range(1, 6);
            f.den_out  = $urandom_range(0, 1);
            f.cfg_req  = $urandom_range(0, 1);
            f.cfg_val  = 2'($urandom_range(0, 3));
            f.exp_err[2] = f.den_out;
            f.exp_err[1] = (f.nl != V);
            f.exp_err[0] = (f.bad_line < f.nl) && (f.bad_len != H) &&
                           (f.bad_line >= 1 || !f.den_out);
            send_frame(f);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cfa_frame_ctrl.md
# cfa_frame_ctrl

Frame sequencer and configuration controller for the CFA demosaic stage. It tracks the raw video timing (vsync/hsync/den) and generates registered pixel coordinates, the Bayer colour phase and a border flag, all aligned to the datapath's one-cycle input delay. It commits a new Bayer pattern only at frame boundaries, and checks every frame against the configured geometry with sticky error flags. It sits between the sensor/raw front end and the demosaic datapath, so the datapath no longer decodes timing itself.

## Interface
- source_h, 1024: expected active pixels per line (den-high cycles per hsync-high period).
- source_v, 1024: expected lines per frame (hsync rising edges per vsync-high period).
- raw_type_init, 0: Bayer pattern after reset. 0 BGGR, 1 RGGB, 2 GBRG, 3 GRBG.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous reset, active high.
- in_vsync, in_hsync, in_den  in  1 each  raw timing, active high.
- cfg_raw_type  in  2  requested pattern.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accepted this cycle when cfg_valid=1.
- err_clr  in  1  clears err_status.
- out_vsync, out_hsync, out_den  out  1 each  one-cycle-delayed timing.
- px_x, px_y  out  12 each  0-based column and line of the current output pixel.
- px_phase  out  2  colour at the pixel: 0 R, 1 Gr, 2 Gb, 3 B.
- px_border  out  1  pixel lies on the outer row or column.
- active_raw_type  out  2  pattern in force.
- frame_active  out  1  state is FRAME.
- frame_done  out  1  one-cycle pulse at end of frame.
- err_status  out  3  sticky: bit0 line length, bit1 line count, bit2 den outside hsync.

## Operation
- **FSM states:** WAIT, IDLE, FRAME, DONE.
  - WAIT: the state after reset. Go to IDLE when in_vsync is sampled low.
  - IDLE: when in_vsync is sampled high, go to FRAME. On that same edge, copy a pending config into active_raw_type, clear the line counter and clear the pending flag.
  - FRAME: when in_vsync is sampled low, go to DONE.
  - DONE: lasts one cycle. Assert frame_done. Set err_status[1] if the line count ≠ source_v. Go to IDLE.
- **Config path:**
  - cfg_ready = !pending.
  - cfg_valid & cfg_ready latches cfg_raw_type into the pending register and sets pending.
  - The latched value is committed only on the IDLE→FRAME transition.
  - A later request is stalled by cfg_ready=0 until the current one is committed.
- **Column counter x:**
  - Clears while in_hsync=0.
  - Increments on each in_den=1 cycle.
  - Saturates at 4095.
- **Line counter y:**
  - Increments on each in_hsync 0→1 edge while in FRAME.
  - The first line of a frame has px_y = 0. The rising edge that starts line 0 does not advance the counter; each later rising edge adds 1.
  - Saturates at 4095.
- **Line length check:** on an in_hsync 1→0 edge in FRAME, set err_status[0] if the den count for that line ≠ source_h.
- **Protocol check:** in_den=1 while in_hsync=0, in FRAME, sets err_status[2].
- **Phase:** px_phase = {y[0], x[0]} XOR off, where off = 2'b11 BGGR, 2'b00 RGGB, 2'b10 GBRG, 2'b01 GRBG (from active_raw_type).
- **Border:** px_border = (x==0) | (y==0) | (x==source_h-1) | (y==source_v-1).
- **Error clearing:** err_clr clears all sticky bits. If an error sets in the same cycle as err_clr, the error wins.
- Frames that start while the FSM is in WAIT are ignored entirely: no counters advance, no checks run, no frame_done.

## Timing
- All outputs are registered.
- **Reset values:**
  - out_vsync, out_hsync, out_den = 0.
  - px_x, px_y = 0; px_phase = 0; px_border = 0.
  - active_raw_type = raw_type_init.
  - frame_active = 0; frame_done = 0.
  - err_status = 0; cfg_ready = 1; pending = 0.
- **Latency:** 1 cycle. out_* and the px_* values for input pixel k appear together in the cycle after in_den for k is sampled.
- **Start of frame:** frame_active rises in the cycle after the edge that samples in_vsync high in IDLE.
- **End of frame:** frame_done is high for exactly the cycle after the edge that first samples in_vsync low in FRAME.
- **Reset mid-frame:**
  - The FSM goes to WAIT, counters clear, pending is dropped and err_status clears.
  - Tracking resumes only after vsync is seen low and then high again.
- cfg_valid during reset is ignored.

## Test plan
- RGGB, 4×4 frame (source_h = source_v = 4), clean timing:
  - Line 0 px_phase = 0,1,0,1; line 1 = 2,3,2,3.
  - px_border is high on x∈{0,3} and y∈{0,3}.
  - frame_done pulses once; err_status = 0.
- cfg_raw_type=0 (BGGR) requested mid-frame:
  - cfg_ready goes low after acceptance.
  - active_raw_type stays 1 until the next vsync rise, then becomes 0.
  - The first pixel of the new frame has px_phase = 3; cfg_ready returns to 1.
- One line of 3 den cycles in a 4-wide frame → err_status = 3'b001 after that line's hsync fall. err_clr then returns it to 0.
- Frame of 3 lines with source_v = 4 → err_status[1] is set in the frame_done cycle.
- in_den pulsed while in_hsync=0 → err_status[2] is set. With err_clr asserted in the same cycle, err_status[2] still reads 1.
- Reset asserted at line 2 of a frame → outputs return to their reset values. The remaining lines of that frame produce no frame_done; the next full frame is processed normally.
